// File: rtl/cc_frame_decoder.sv
// Frame-rate Command & Control decoder.
// Each CLRCLK edge evaluates one 59-bit C&C word. The word is classified as
// missed, foreign, bad or good. Good words vote on a candidate configuration
// tuple, and the committed registers load once enough consecutive good frames
// agree. A link watchdog forces PTT off when frames stop arriving.
module cc_frame_decoder #(
  parameter logic [3:0]  MY_ADDR = 4'd0,
  parameter int          CONFIRM = 2,
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] FMAX    = 32'd65000000
) (
  input  logic        CLRCLK,
  input  logic        reset,
  input  logic [58:0] cc_word,
  input  logic        cc_valid,
  output logic        PTT_out,
  output logic [31:0] frequency_HZ,
  output logic        freq_changed,
  output logic [3:0]  clock_select,
  output logic [6:0]  OC,
  output logic        mode,
  output logic        link_ok,
  output logic [7:0]  frame_err_count
);

  // Configuration tuple. The field order matches cc_word[53:10], so one
  // slice of the word fills the whole struct.
  typedef struct packed {
    logic [31:0] freq;
    logic [3:0]  clk_sel;
    logic [6:0]  oc;
    logic        mode;
  } cfg_t;

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    ACQUIRE   = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  localparam logic [1:0] CNT_MAX = 2'(CONFIRM);
  localparam logic [7:0] WD_MAX  = 8'(TIMEOUT);
  localparam logic [7:0] ERR_MAX = 8'd255;

  // Fields of the incoming word.
  logic       frame_ptt;
  logic [3:0] frame_addr;
  cfg_t       frame_cfg;
  logic       unused_pad;

  assign frame_ptt  = cc_word[58];
  assign frame_addr = cc_word[57:54];
  assign frame_cfg  = cc_word[53:10];
  assign unused_pad = ^cc_word[9:0];

  // Frame classification.
  logic addr_hit;
  logic frame_good;
  logic frame_bad;
  logic frame_missed;

  assign addr_hit     = cc_valid && (frame_addr == MY_ADDR);
  assign frame_good   = addr_hit && (frame_cfg.freq <= FMAX);
  assign frame_bad    = addr_hit && (frame_cfg.freq >  FMAX);
  assign frame_missed = !cc_valid;

  // Registered state.
  state_t     state;
  logic [7:0] wd;
  cfg_t       cand;
  logic [1:0] cnt;
  cfg_t       cfg_q;

  // Next-state values.
  state_t     state_n;
  logic [7:0] wd_n;
  cfg_t       cand_n;
  logic [1:0] cnt_n;
  cfg_t       cfg_n;
  logic       ptt_n;
  logic       fc_n;
  logic [7:0] err_n;
  logic       link_n;
  logic       timeout;
  logic       confirmed;
  logic       commit;

  // Watchdog, agreement counter, error counter and commit decision.
  always_comb begin
    // NOTE: every signal gets a default first. Without it, a path that
    // assigns nothing would make synthesis infer a latch.
    wd_n      = wd;
    cand_n    = cand;
    cnt_n     = cnt;
    cfg_n     = cfg_q;
    fc_n      = 1'b0;
    err_n     = frame_err_count;
    timeout   = 1'b0;
    confirmed = 1'b0;
    commit    = 1'b0;

    // A missed frame advances the watchdog. Any other frame clears it, so a
    // good frame that arrives on the would-be timeout edge prevents the timeout.
    if (frame_missed) begin
      wd_n    = (wd >= WD_MAX) ? WD_MAX : wd + 8'd1;
      timeout = (wd_n == WD_MAX);
    end else begin
      wd_n = '0;
    end

    // Agreement. Foreign and missed frames leave cand and cnt untouched,
    // so they can be interleaved without breaking a pending confirmation.
    if (frame_good) begin
      if (frame_cfg == cand) begin
        cnt_n = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 2'd1;
      end else begin
        cand_n = frame_cfg;
        cnt_n  = 2'd1;
      end
    end else if (frame_bad) begin
      cnt_n = '0;
      err_n = (frame_err_count == ERR_MAX) ? ERR_MAX : frame_err_count + 8'd1;
    end

    confirmed = frame_good && (cnt_n == CNT_MAX);
    commit    = confirmed && (cand_n != cfg_q);

    if (commit) begin
      cfg_n = cand_n;
      fc_n  = (cand_n.freq != cfg_q.freq);
    end

    // Losing the link discards any half-agreed candidate. The committed
    // config is kept so the radio holds its last settings.
    if (timeout) begin
      cand_n = '0;
      cnt_n  = '0;
    end
  end

  // Link state machine: next state and next PTT.
  always_comb begin
    state_n = state;
    ptt_n   = PTT_out;

    case (state)
      LINK_DOWN: begin
        ptt_n = 1'b0;
        if (frame_good) state_n = ACQUIRE;
      end
      ACQUIRE: begin
        ptt_n = 1'b0;
        // Full agreement reached, whether or not it changed the config.
        if (confirmed) state_n = LOCKED;
      end
      LOCKED: begin
        if (frame_good)     ptt_n = frame_ptt;
        else if (frame_bad) ptt_n = 1'b0;
      end
      default: begin
        state_n = LINK_DOWN;
        ptt_n   = 1'b0;
      end
    endcase

    if (timeout) begin
      state_n = LINK_DOWN;
      ptt_n   = 1'b0;
    end

    link_n = (state_n == LOCKED);
  end

  // State and output registers. Reset is asynchronous and clears everything.
  always_ff @(posedge CLRCLK or posedge reset) begin
    if (reset) begin
      state           <= LINK_DOWN;
      wd              <= '0;
      cand            <= '0;
      cnt             <= '0;
      cfg_q           <= '0;
      PTT_out         <= 1'b0;
      freq_changed    <= 1'b0;
      link_ok         <= 1'b0;
      frame_err_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment. All registers
      // then update together from values sampled before the edge.
      state           <= state_n;
      wd              <= wd_n;
      cand            <= cand_n;
      cnt             <= cnt_n;
      cfg_q           <= cfg_n;
      PTT_out         <= ptt_n;
      freq_changed    <= fc_n;
      link_ok         <= link_n;
      frame_err_count <= err_n;
    end
  end

  assign frequency_HZ = cfg_q.freq;
  assign clock_select = cfg_q.clk_sel;
  assign OC           = cfg_q.oc;
  assign mode         = cfg_q.mode;

endmodule

// File: tb/tb_cc_frame_decoder.sv
// Directed bench for cc_frame_decoder with the default parameters
// (MY_ADDR=0, CONFIRM=2, TIMEOUT=16, FMAX=65 MHz).
module tb_cc_frame_decoder;

  logic        CLRCLK;
  logic        reset;
  logic [58:0] cc_word;
  logic        cc_valid;
  logic        PTT_out;
  logic [31:0] frequency_HZ;
  logic        freq_changed;
  logic [3:0]  clock_select;
  logic [6:0]  OC;
  logic        mode;
  logic        link_ok;
  logic [7:0]  frame_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] F22  = 32'd22000000;
  localparam logic [31:0] F14  = 32'd14000000;
  localparam logic [31:0] F7   = 32'd7000000;
  localparam logic [31:0] F65  = 32'd65000000;
  localparam logic [31:0] F70  = 32'd70000000;
  localparam logic [31:0] F35  = 32'd3500000;
  localparam logic [3:0]  CS_A = 4'b1010;
  localparam logic [6:0]  OC_A = 7'b1011010;
  localparam logic [3:0]  CS_B = 4'b0101;
  localparam logic [6:0]  OC_B = 7'b0100101;

  cc_frame_decoder dut (
    .CLRCLK          (CLRCLK),
    .reset           (reset),
    .cc_word         (cc_word),
    .cc_valid        (cc_valid),
    .PTT_out         (PTT_out),
    .frequency_HZ    (frequency_HZ),
    .freq_changed    (freq_changed),
    .clock_select    (clock_select),
    .OC              (OC),
    .mode            (mode),
    .link_ok         (link_ok),
    .frame_err_count (frame_err_count)
  );

  initial CLRCLK = 1'b0;
  always #5 CLRCLK = ~CLRCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic        ptt;
    logic [3:0]  addr;
    logic [31:0] freq;
    logic [3:0]  cs;
    logic [6:0]  oc;
    logic        md;
    logic        e_ptt;
    logic [31:0] e_freq;
    logic        e_fc;
    logic [3:0]  e_cs;
    logic [6:0]  e_oc;
    logic        e_md;
    logic        e_link;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs [23];

  // The pad bits carry a non-zero pattern so that any use of them shows up.
  function automatic logic [58:0] mk(input logic p, input logic [3:0] a,
                                     input logic [31:0] f, input logic [3:0] cs,
                                     input logic [6:0] oc, input logic m);
    return {p, a, f, cs, oc, m, 10'h2A5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ptt, input logic [31:0] e_freq,
                           input logic e_fc, input logic [3:0] e_cs, input logic [6:0] e_oc,
                           input logic e_md, input logic e_link, input logic [7:0] e_err);
    check({tag, " PTT_out"},         32'(PTT_out),         32'(e_ptt));
    check({tag, " frequency_HZ"},    frequency_HZ,         e_freq);
    check({tag, " freq_changed"},    32'(freq_changed),    32'(e_fc));
    check({tag, " clock_select"},    32'(clock_select),    32'(e_cs));
    check({tag, " OC"},              32'(OC),              32'(e_oc));
    check({tag, " mode"},            32'(mode),            32'(e_md));
    check({tag, " link_ok"},         32'(link_ok),         32'(e_link));
    check({tag, " frame_err_count"}, 32'(frame_err_count), 32'(e_err));
  endtask

  // Present one frame, take the edge, then sample 1 time unit later.
  task automatic apply(input logic valid, input logic [58:0] word);
    cc_valid = valid;
    cc_word  = word;
    @(posedge CLRCLK);
    #1;
  endtask

  initial begin
    // Row layout: valid ptt addr freq cs oc md | ptt freq fc cs oc md link err
    vecs[0]  = '{1, 1, 0, F22, CS_A, OC_A, 1,   0, 0,   0, 0,    0,    0, 0, 0};
    vecs[1]  = '{1, 1, 0, F22, CS_A, OC_A, 1,   0, F22, 1, CS_A, OC_A, 1, 1, 0};
    vecs[2]  = '{1, 1, 0, F22, CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[3]  = '{1, 1, 0, F14, CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[4]  = '{1, 1, 0, F7,  CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[5]  = '{1, 1, 0, F14, CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[6]  = '{1, 1, 0, F7,  CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[7]  = '{1, 1, 0, F14, CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[8]  = '{1, 0, 0, F22, CS_A, OC_A, 1,   0, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[9]  = '{1, 1, 0, F22, CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 0};
    vecs[10] = '{1, 1, 0, F70, CS_A, OC_A, 1,   0, F22, 0, CS_A, OC_A, 1, 1, 1};
    vecs[11] = '{1, 1, 0, F22, CS_A, OC_A, 1,   1, F22, 0, CS_A, OC_A, 1, 1, 1};
    vecs[12] = '{1, 0, 3, F35, CS_B, OC_B, 0,   1, F22, 0, CS_A, OC_A, 1, 1, 1};
    vecs[13] = '{0, 0, 0, 0,   0,    0,    0,   1, F22, 0, CS_A, OC_A, 1, 1, 1};
    vecs[14] = '{1, 1, 0, F7,  CS_B, OC_B, 0,   1, F22, 0, CS_A, OC_A, 1, 1, 1};
    vecs[15] = '{0, 0, 0, 0,   0,    0,    0,   1, F22, 0, CS_A, OC_A, 1, 1, 1};
    vecs[16] = '{1, 1, 3, F7,  CS_B, OC_B, 0,   1, F22, 0, CS_A, OC_A, 1, 1, 1};
    vecs[17] = '{1, 1, 0, F7,  CS_B, OC_B, 0,   1, F7,  1, CS_B, OC_B, 0, 1, 1};
    vecs[18] = '{1, 1, 0, F7,  CS_B, OC_B, 0,   1, F7,  0, CS_B, OC_B, 0, 1, 1};
    vecs[19] = '{1, 1, 0, F65, CS_B, OC_B, 0,   1, F7,  0, CS_B, OC_B, 0, 1, 1};
    vecs[20] = '{1, 1, 0, F65 + 32'd1, CS_B, OC_B, 0, 0, F7, 0, CS_B, OC_B, 0, 1, 2};
    vecs[21] = '{1, 1, 0, F65, CS_B, OC_B, 0,   1, F7,  0, CS_B, OC_B, 0, 1, 2};
    vecs[22] = '{1, 1, 0, F65, CS_B, OC_B, 0,   1, F65, 1, CS_B, OC_B, 0, 1, 2};

    reset    = 1'b1;
    cc_valid = 1'b0;
    cc_word  = '0;
    repeat (2) @(posedge CLRCLK);
    #1;
    reset = 1'b0;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Main table.
    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].valid, mk(vecs[i].ptt, vecs[i].addr, vecs[i].freq,
                              vecs[i].cs, vecs[i].oc, vecs[i].md));
      check_all($sformatf("vec%0d", i), vecs[i].e_ptt, vecs[i].e_freq, vecs[i].e_fc,
                vecs[i].e_cs, vecs[i].e_oc, vecs[i].e_md, vecs[i].e_link, vecs[i].e_err);
    end

    // The error counter saturates at 255. It starts at 2 here.
    for (int i = 0; i < 252; i++) apply(1'b1, mk(1, 0, F70, CS_B, OC_B, 0));
    check("err_sat 254", 32'(frame_err_count), 32'd254);
    apply(1'b1, mk(1, 0, F70, CS_B, OC_B, 0));
    check("err_sat 255", 32'(frame_err_count), 32'd255);
    for (int i = 0; i < 47; i++) apply(1'b1, mk(1, 0, F70, CS_B, OC_B, 0));
    check_all("err_sat hold", 0, F65, 0, CS_B, OC_B, 0, 1, 8'd255);

    // Watchdog: 15 missed frames keep the link, the 16th drops it.
    apply(1'b1, mk(1, 0, F65, CS_B, OC_B, 0));
    check("wd pre ptt", 32'(PTT_out), 32'd1);
    for (int i = 0; i < 15; i++) apply(1'b0, '0);
    check("wd15 link_ok", 32'(link_ok), 32'd1);
    check("wd15 PTT_out", 32'(PTT_out), 32'd1);
    apply(1'b0, '0);
    check_all("wd16", 0, F65, 0, CS_B, OC_B, 0, 0, 8'd255);

    // Relock. The candidate matches the committed config, so no commit occurs.
    apply(1'b1, mk(1, 0, F65, CS_B, OC_B, 0));
    check("relock1 link_ok", 32'(link_ok), 32'd0);
    check("relock1 PTT_out", 32'(PTT_out), 32'd0);
    apply(1'b1, mk(1, 0, F65, CS_B, OC_B, 0));
    check_all("relock2", 0, F65, 0, CS_B, OC_B, 0, 1, 8'd255);
    apply(1'b1, mk(1, 0, F65, CS_B, OC_B, 0));
    check("relock3 PTT_out", 32'(PTT_out), 32'd1);

    // A good frame on the would-be timeout edge restarts the watchdog.
    for (int i = 0; i < 15; i++) apply(1'b0, '0);
    apply(1'b1, mk(1, 0, F65, CS_B, OC_B, 0));
    check("wd_rescue link_ok", 32'(link_ok), 32'd1);
    for (int i = 0; i < 15; i++) apply(1'b0, '0);
    check("wd_rescue+15 link_ok", 32'(link_ok), 32'd1);
    apply(1'b0, '0);
    check("wd_rescue+16 link_ok", 32'(link_ok), 32'd0);

    // Foreign frames: the outputs stay put and the watchdog never expires.
    apply(1'b1, mk(0, 0, F65, CS_B, OC_B, 0));
    apply(1'b1, mk(0, 0, F65, CS_B, OC_B, 0));
    check("foreign pre link_ok", 32'(link_ok), 32'd1);
    for (int i = 0; i < 100; i++) begin
      apply(1'b1, mk(1, 4'd3, F35, CS_A, OC_A, 1));
      check($sformatf("foreign%0d PTT_out", i), 32'(PTT_out), 32'd0);
      check($sformatf("foreign%0d link_ok", i), 32'(link_ok), 32'd1);
    end
    check_all("foreign end", 0, F65, 0, CS_B, OC_B, 0, 1, 8'd255);

    // Reset between the two confirming frames clears everything at once.
    apply(1'b1, mk(1, 0, F22, CS_A, OC_A, 1));
    #2 reset = 1'b1;
    #1 check_all("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    apply(1'b1, mk(1, 0, F22, CS_A, OC_A, 1));
    check_all("post_reset1", 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1'b1, mk(1, 0, F22, CS_A, OC_A, 1));
    check_all("post_reset2", 0, F22, 1, CS_A, OC_A, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
